// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-address sequencer: vectors, next-PC
// select codes and the sequencer state encoding.
package pc_sequencer_pkg;

   // Fetch address after reset and after a fault handler acknowledge
   localparam logic [31:0] PC_RESET_VEC   = 32'h0000_3000;
   localparam logic [31:0] PC_HANDLER_VEC = 32'h0000_4180;

   // Next-PC select: same encoding as the NPC unit feeding this block
   localparam int NPC_SEL_W = 2;
   typedef enum logic [NPC_SEL_W-1:0] {
      NPC_BRANCH = 2'd0,
      NPC_JUMP   = 2'd1,
      NPC_JR     = 2'd2,
      NPC_SEQ    = 2'd3
   } npc_sel_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FAULT = 2'd3
   } seq_state_e;

   localparam int          TAKEN_CNT_W   = 16;
   localparam logic [15:0] TAKEN_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pc_sequencer_target_mux.sv
// Combinational next-PC target selection. A bubble in D (d_valid=0)
// always falls back to the sequential address and is never "taken".
module pc_target_mux
   import pc_sequencer_pkg::*;
(
   input  logic [NPC_SEL_W-1:0] npc_sel,
   input  logic                 d_valid,
   input  logic                 cmp,
   input  logic signed [31:0]   im32,
   input  logic [25:0]          im26,
   input  logic [31:0]          reg_pc,
   input  logic [31:0]          pc_f,
   input  logic [31:0]          pc4_d,
   output logic [31:0]          target,
   output logic                 taken
);

   logic signed [31:0] br_off;

   // Select the redirect target and flag whether it is a taken redirect
   always_comb begin
      br_off = im32 <<< 2;
      target = pc_f + 32'd4;
      taken  = 1'b0;
      if (d_valid) begin
         unique case (npc_sel_e'(npc_sel))
            NPC_BRANCH: begin
               if (cmp) begin
                  target = pc4_d + $unsigned(br_off);
                  taken  = 1'b1;
               end
            end
            NPC_JUMP: begin
               target = {pc4_d[31:28], im26, 2'b00};
               taken  = 1'b1;
            end
            NPC_JR: begin
               target = reg_pc;
               taken  = 1'b1;
            end
            NPC_SEQ: begin
               target = pc_f + 32'd4;
            end
         endcase
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: owns pc_f / pc4_d, the BOOT/RUN/STALL/FAULT
// state machine, misaligned-target fault capture and the taken counter.
// Every output comes straight from a flop.
module pc_sequencer
   import pc_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 d_valid,
   input  logic [NPC_SEL_W-1:0] npc_sel,
   input  logic                 cmp,
   input  logic signed [31:0]   im32,
   input  logic [25:0]          im26,
   input  logic [31:0]          reg_pc,
   input  logic                 fault_clr,
   output logic [31:0]          pc_f,
   output logic                 f_valid,
   output logic [31:0]          pc4_d,
   output logic                 fault,
   output logic [31:0]          fault_pc,
   output logic [15:0]          taken_cnt
);

   seq_state_e             state_q, state_d;
   logic [31:0]            pc_f_q, pc_f_d;
   logic [31:0]            pc4_d_q, pc4_d_d;
   logic                   f_valid_q, f_valid_d;
   logic                   fault_q, fault_d;
   logic [31:0]            fault_pc_q, fault_pc_d;
   logic [TAKEN_CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic [31:0] target;
   logic        taken;

   // Saturating increment of the taken-redirect counter
   function automatic logic [TAKEN_CNT_W-1:0] sat_inc(input logic [TAKEN_CNT_W-1:0] v);
      if (v == TAKEN_CNT_MAX) return v;
      return v + 1'b1;
   endfunction

   pc_target_mux u_target_mux (
      .npc_sel (npc_sel),
      .d_valid (d_valid),
      .cmp     (cmp),
      .im32    (im32),
      .im26    (im26),
      .reg_pc  (reg_pc),
      .pc_f    (pc_f_q),
      .pc4_d   (pc4_d_q),
      .target  (target),
      .taken   (taken)
   );

   // Next-state and next-register computation for the whole sequencer
   always_comb begin
      state_d     = state_q;
      pc_f_d      = pc_f_q;
      pc4_d_d     = pc4_d_q;
      fault_d     = fault_q;
      fault_pc_d  = fault_pc_q;
      taken_cnt_d = taken_cnt_q;
      unique case (state_q)
         ST_BOOT: begin
            // One idle cycle, fetch starts from the unchanged reset vector
            state_d = ST_RUN;
         end
         ST_RUN, ST_STALL: begin
            if (stall) begin
               // Freeze F and D; the held D inputs are re-evaluated later
               state_d = ST_STALL;
            end else begin
               if (taken) taken_cnt_d = sat_inc(taken_cnt_q);
               if (d_valid && (target[1:0] != 2'b00)) begin
                  state_d    = ST_FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = target;
               end else begin
                  pc_f_d  = target;
                  pc4_d_d = pc_f_q + 32'd4;
                  state_d = ST_RUN;
               end
            end
         end
         ST_FAULT: begin
            // Only the handler acknowledge is honoured here
            if (fault_clr) begin
               pc_f_d  = PC_HANDLER_VEC;
               fault_d = 1'b0;
               state_d = ST_RUN;
            end
         end
      endcase
      f_valid_d = (state_d == ST_RUN) || (state_d == ST_STALL);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         pc_f_q      <= PC_RESET_VEC;
         pc4_d_q     <= PC_RESET_VEC;
         f_valid_q   <= 1'b0;
         fault_q     <= 1'b0;
         fault_pc_q  <= 32'h0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_f_q      <= pc_f_d;
         pc4_d_q     <= pc4_d_d;
         f_valid_q   <= f_valid_d;
         fault_q     <= fault_d;
         fault_pc_q  <= fault_pc_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc_f      = pc_f_q;
   assign pc4_d     = pc4_d_q;
   assign f_valid   = f_valid_q;
   assign fault     = fault_q;
   assign fault_pc  = fault_pc_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the fetch sequencer.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        d_valid;
   logic [1:0]  npc_sel;
   logic        cmp;
   logic [31:0] im32;
   logic [25:0] im26;
   logic [31:0] reg_pc;
   logic        fault_clr;
   logic [31:0] pc_f;
   logic        f_valid;
   logic [31:0] pc4_d;
   logic        fault;
   logic [31:0] fault_pc;
   logic [15:0] taken_cnt;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: mode 0 = booting, 1 = fetching, 2 = faulted
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_pc4;
   logic        m_fault;
   logic [31:0] m_fpc;
   int          m_cnt;

   pc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .d_valid   (d_valid),
      .npc_sel   (npc_sel),
      .cmp       (cmp),
      .im32      (im32),
      .im26      (im26),
      .reg_pc    (reg_pc),
      .fault_clr (fault_clr),
      .pc_f      (pc_f),
      .f_valid   (f_valid),
      .pc4_d     (pc4_d),
      .fault     (fault),
      .fault_pc  (fault_pc),
      .taken_cnt (taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      logic [31:0] tgt;
      logic [31:0] off;
      logic [31:0] idx;
      bit          tk;
      if (!reset) begin
         m_mode = 0; m_pc = 32'h3000; m_pc4 = 32'h3000;
         m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (!stall) begin
            tgt = m_pc + 32'd4;
            tk  = 1'b0;
            if (d_valid) begin
               if (npc_sel == 2'd0 && cmp) begin
                  off = im32 * 32'd4;
                  tgt = m_pc4 + off;
                  tk  = 1'b1;
               end else if (npc_sel == 2'd1) begin
                  idx = {6'd0, im26};
                  tgt = (m_pc4 & 32'hF000_0000) + idx * 32'd4;
                  tk  = 1'b1;
               end else if (npc_sel == 2'd2) begin
                  tgt = reg_pc;
                  tk  = 1'b1;
               end
            end
            if (tk && m_cnt < 65535) m_cnt++;
            if (tgt % 4 != 0) begin
               m_mode = 2; m_fault = 1'b1; m_fpc = tgt;
            end else begin
               m_pc4 = m_pc + 32'd4;
               m_pc  = tgt;
            end
         end
      end else begin
         if (fault_clr) begin
            m_mode = 1; m_pc = 32'h4180; m_fault = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc_f"}, pc_f, m_pc);
      chk({tag, ".pc4_d"}, pc4_d, m_pc4);
      chk({tag, ".f_valid"}, {31'd0, f_valid}, {31'd0, (m_mode == 1)});
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
      chk({tag, ".fault_pc"}, fault_pc, m_fpc);
      chk({tag, ".taken_cnt"}, {16'd0, taken_cnt}, m_cnt);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      stall = 1'b0; d_valid = 1'b0; npc_sel = 2'd3; cmp = 1'b0;
      im32 = 32'd0; im26 = 26'd0; reg_pc = 32'd0; fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step("rst0");
      step("rst1");
      reset = 1'b1;
   endtask

   initial begin
      logic [15:0] cnt_before;
      logic [31:0] r;
      reset = 1'b0;
      idle_inputs();
      m_mode = 0; m_pc = 32'h3000; m_pc4 = 32'h3000;
      m_fault = 1'b0; m_fpc = 32'h0; m_cnt = 0;

      // Reset sequence: BOOT, then sequential fetch from the reset vector
      do_reset();
      chk("boot.pc_f", pc_f, 32'h3000);
      chk("boot.f_valid", {31'd0, f_valid}, 32'd0);
      step("run0");
      chk("run0.pc_f", pc_f, 32'h3000);
      chk("run0.f_valid", {31'd0, f_valid}, 32'd1);
      step("run1");
      chk("run1.pc_f", pc_f, 32'h3004);
      step("run2");
      chk("run2.pc_f", pc_f, 32'h3008);
      chk("run2.f_valid", {31'd0, f_valid}, 32'd1);

      // Build pc_f=0x3008 / pc4_d=0x3004 via a jr from 0x3000, then beq
      do_reset();
      step("boot2");
      d_valid = 1'b1; npc_sel = 2'd2; reg_pc = 32'h3008;
      step("jr3008");
      chk("jr.pc4_d", pc4_d, 32'h3004);
      npc_sel = 2'd0; cmp = 1'b1; im32 = 32'd4;
      cnt_before = taken_cnt;
      step("beq_t");
      chk("beq_t.pc_f", pc_f, 32'h3014);
      chk("beq_t.cnt", {16'd0, taken_cnt}, {16'd0, cnt_before + 16'd1});
      cmp = 1'b0;
      cnt_before = taken_cnt;
      step("beq_nt");
      chk("beq_nt.pc_f", pc_f, 32'h3018);
      chk("beq_nt.cnt", {16'd0, taken_cnt}, {16'd0, cnt_before});

      // Backward branch with negative offset
      cmp = 1'b1; im32 = 32'hFFFF_FFF8;
      step("beq_neg");

      // Stall beats a jr for three cycles, then the jr takes effect
      npc_sel = 2'd2; reg_pc = 32'h3100; stall = 1'b1;
      r = pc_f;
      cnt_before = taken_cnt;
      for (int i = 0; i < 3; i++) step("stall");
      chk("stall.pc_f", pc_f, r);
      chk("stall.cnt", {16'd0, taken_cnt}, {16'd0, cnt_before});
      chk("stall.f_valid", {31'd0, f_valid}, 32'd1);
      stall = 1'b0;
      step("unstall");
      chk("unstall.pc_f", pc_f, 32'h3100);

      // Misaligned jr: fault captured, fetch held and invalid
      reg_pc = 32'h3102;
      r = pc_f;
      step("misal");
      chk("misal.fault", {31'd0, fault}, 32'd1);
      chk("misal.fault_pc", fault_pc, 32'h3102);
      chk("misal.f_valid", {31'd0, f_valid}, 32'd0);
      chk("misal.pc_f", pc_f, r);
      // Everything but fault_clr is ignored while faulted
      npc_sel = 2'd1; im26 = 26'h0000C40; stall = 1'b1;
      step("fault_ign0");
      stall = 1'b0;
      step("fault_ign1");
      fault_clr = 1'b1;
      step("fclr");
      chk("fclr.pc_f", pc_f, 32'h4180);
      chk("fclr.fault", {31'd0, fault}, 32'd0);
      chk("fclr.fault_pc", fault_pc, 32'h3102);
      chk("fclr.f_valid", {31'd0, f_valid}, 32'd1);
      // fault_clr outside FAULT does nothing; bubble with npc_sel=1 is sequential
      d_valid = 1'b0;
      cnt_before = taken_cnt;
      step("clr_run");
      chk("bubble.pc_f", pc_f, 32'h4184);
      chk("bubble.cnt", {16'd0, taken_cnt}, {16'd0, cnt_before});
      fault_clr = 1'b0;

      // Reset while stalled and while faulted
      stall = 1'b1;
      step("stall_pre");
      reset = 1'b0;
      step("rst_stall");
      reset = 1'b1; stall = 1'b0;
      step("boot3");
      d_valid = 1'b1; npc_sel = 2'd2; reg_pc = 32'h0000_0001;
      step("misal2");
      reset = 1'b0;
      step("rst_fault");
      reset = 1'b1;
      idle_inputs();
      step("boot4");

      // Saturation: 70000 taken jumps
      d_valid = 1'b1; npc_sel = 2'd1; im26 = 26'h0000C00;
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk);
         model_step();
      end
      #1;
      check_all("sat");
      chk("sat.cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);
      d_valid = 1'b0;
      r = pc_f;
      step("sat_bubble");
      chk("sat_bubble.pc_f", pc_f, r + 32'd4);
      chk("sat_bubble.cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 79) != 0);
         stall     = ($urandom_range(0, 3) == 0);
         d_valid   = ($urandom_range(0, 3) != 0);
         npc_sel   = 2'($urandom_range(0, 3));
         cmp       = 1'($urandom_range(0, 1));
         im32      = 32'($signed($urandom_range(0, 256)) - 128);
         im26      = 26'($urandom);
         r         = $urandom;
         r[1:0]    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         reg_pc    = r;
         fault_clr = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-003 SHALL have port stall, input, 1 bit: hazard unit freeze of the F and D stages.
REQ-004 SHALL have port d_valid, input, 1 bit: the D-stage instruction is real, not a bubble.
REQ-005 SHALL have port npc_sel, input, 2 bits: 0 branch, 1 j/jal, 2 jr, 3 sequential.
REQ-006 SHALL have port cmp, input, 1 bit: branch condition result for the D-stage instruction.
REQ-007 SHALL have port im32, input, 32 bits: sign-extended branch offset in words.
REQ-008 SHALL have port im26, input, 26 bits: jump index.
REQ-009 SHALL have port reg_pc, input, 32 bits: forwarded rs value for jr.
REQ-010 SHALL have port fault_clr, input, 1 bit: handler acknowledge that leaves FAULT.
REQ-011 SHALL have port pc_f, output, 32 bits: fetch address.
REQ-012 SHALL have port f_valid, output, 1 bit: pc_f is a real fetch.
REQ-013 SHALL have port pc4_d, output, 32 bits: PC+4 of the D-stage instruction.
REQ-014 SHALL have port fault, output, 1 bit: misaligned redirect target captured.
REQ-015 SHALL have port fault_pc, output, 32 bits: offending target address.
REQ-016 SHALL have port taken_cnt, output, 16 bits: saturating count of taken redirects.

Function
REQ-017 SHALL implement states BOOT, RUN, STALL, FAULT, with BOOT as the reset state.
REQ-018 BOOT SHALL last exactly one cycle with f_valid=0, then go to RUN with pc_f unchanged.
REQ-019 A redirect SHALL be requested only when the state is RUN or STALL, d_valid=1 and stall=0.
REQ-020 The redirect target SHALL be computed as follows:
- npc_sel=0 with cmp=1: pc4_d+(im32<<2), 32-bit wrap.
- npc_sel=0 with cmp=0: pc_f+4.
- npc_sel=1: {pc4_d[31:28],im26,2'b00}.
- npc_sel=2: reg_pc.
- npc_sel=3, or d_valid=0: pc_f+4.
REQ-021 In RUN or STALL with stall=0 and an aligned next address, the block SHALL load pc_f<=next and pc4_d<=pc_f+4, and the state SHALL become RUN.
REQ-022 Delay slot: the instruction at old pc_f+4 SHALL always be fetched before the target, so latency from redirect decode to the target on pc_f is one cycle.
REQ-023 When stall=1, pc_f, pc4_d and taken_cnt SHALL hold, and the state SHALL be STALL; stall beats a simultaneous redirect, which is re-evaluated from held D inputs once stall=0.
REQ-024 A taken redirect SHALL increment taken_cnt:
- taken means npc_sel=0 with cmp=1, or npc_sel=1 or 2;
- the count saturates at 0xFFFF;
- there is no increment when stall=1 or in FAULT.
REQ-025 When a redirect target has target[1:0]!=0, the block SHALL:
- go to FAULT;
- hold pc_f;
- set fault=1 and fault_pc=target;
- set f_valid=0.
REQ-026 In FAULT, every input except fault_clr and reset SHALL be ignored.
REQ-027 On fault_clr=1 in FAULT, the block SHALL load pc_f<=0x0000_4180, clear fault, keep fault_pc, and return to RUN; fault_clr outside FAULT has no effect.
REQ-028 f_valid SHALL be 1 exactly in RUN and STALL.
REQ-029 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 While reset=0 at a clock edge, the block SHALL set:
- pc_f=0x0000_3000, pc4_d=0x0000_3000;
- fault=0, fault_pc=0, taken_cnt=0;
- state BOOT, f_valid=0.
REQ-031 Reset SHALL override every other input in every state, including mid-stall and mid-FAULT.

Structure
REQ-032 The shared header SHALL define the following (npc_sel values stay consistent with the existing NPC encoding):
- PC reset vector 0x0000_3000 and handler vector 0x0000_4180;
- npc_sel width and its four codes;
- the state encoding.
REQ-033 Target selection SHALL be one combinational sub-module, pc_target_mux; the state machine and registers stay in pc_sequencer.

Verification
REQ-034 Reset sequence: reset=0 for 2 cycles, then 1 -> pc_f=0x3000, f_valid=0 for one cycle, then 0x3004, 0x3008 with f_valid=1.
REQ-035 Taken beq: pc_f=0x3008, pc4_d=0x3004, npc_sel=0, cmp=1, im32=4, d_valid=1 -> next pc_f=0x3014, taken_cnt=1; with cmp=0 -> 0x300C, count unchanged.
REQ-036 Stall against jr: stall=1 for 3 cycles with npc_sel=2, reg_pc=0x3100 -> pc_f held, count held; on the first cycle with stall=0 -> pc_f=0x3100.
REQ-037 Misaligned jr: reg_pc=0x3102 -> fault=1, fault_pc=0x3102, f_valid=0, pc_f held; fault_clr pulse -> pc_f=0x4180, RUN, fault=0.
REQ-038 Saturation and bubbles: 70000 taken j -> taken_cnt=0xFFFF; d_valid=0 with npc_sel=1 -> sequential pc_f+4 and no count.
